// File: rtl/instr_mem_responder.sv
// Instruction memory responder: byte-stream program loader plus zero-latency halfword-aligned fetch port.
// Optional build macro LOAD_CHECKSUM_EN adds a trailing modulo-256 checksum byte check after load_last.
module instr_mem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] END_MARKER  = 32'h00001111
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           load_valid,
   input  logic [7:0]                     load_byte,
   input  logic                           load_last,
   output logic                           load_ready,
   input  logic                           reload,
   input  logic [31:0]                    address,
   output logic [31:0]                    data,
   output logic                           run_flag,
   output logic                           load_error,
   output logic [$clog2(DEPTH_WORDS):0]   word_count
);

   localparam int              N        = $clog2(DEPTH_WORDS);
   localparam int              WC_W     = N + 1;
   localparam logic [WC_W-1:0] FULL_CNT = WC_W'(DEPTH_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHK,
      S_PAD,
      S_END,
      S_RUN,
      S_ERR
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [1:0]        r_cnt;
   logic [31:0]       r_asm;
   logic [WC_W-1:0]   r_word_count;
   logic [15:0]       r_lo [DEPTH_WORDS];
   logic [15:0]       r_hi [DEPTH_WORDS];

   logic              w_accept;
   logic              w_take;
   logic              w_full;
   logic              w_wr_en;
   logic [31:0]       w_wr_data;
   logic [N-1:0]      w_idx;
   logic [N-1:0]      w_idx_nx;
   logic              w_in_range;
   logic              w_cur_ok;
   logic              w_nx_ok;

`ifdef LOAD_CHECKSUM_EN
   logic [7:0]        r_sum;
   assign load_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_CHK);
`else
   assign load_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
`endif

   assign w_accept   = load_valid && load_ready;
   assign w_take     = w_accept && ((r_state == S_IDLE) || (r_state == S_LOAD));
   assign w_full     = (r_word_count == FULL_CNT);
   assign run_flag   = (r_state == S_RUN);
   assign load_error = (r_state == S_ERR);
   assign word_count = r_word_count;

   always_comb begin
      w_next_state = r_state;
      w_wr_en      = 1'b0;
      w_wr_data    = r_asm;
      case (r_state)
         S_IDLE, S_LOAD: begin
            if (w_accept) begin
               w_next_state = S_LOAD;
               if (r_cnt == 2'd3) begin
                  w_wr_data = {load_byte, r_asm[23:0]};
                  if (w_full) w_next_state = S_ERR;
                  else        w_wr_en      = 1'b1;
               end
               if (load_last && (w_next_state != S_ERR)) begin
`ifdef LOAD_CHECKSUM_EN
                  w_next_state = S_CHK;
`else
                  w_next_state = (r_cnt == 2'd3) ? S_END : S_PAD;
`endif
               end
            end
         end
`ifdef LOAD_CHECKSUM_EN
         S_CHK: begin
            // A lane-3 last byte already wrote its word, leaving cnt at 0.
            if (w_accept) begin
               if (load_byte != r_sum) w_next_state = S_ERR;
               else                    w_next_state = (r_cnt != 2'd0) ? S_PAD : S_END;
            end
         end
`endif
         S_PAD: begin
            w_next_state = S_END;
            if (w_full) w_next_state = S_ERR;
            else        w_wr_en      = 1'b1;
         end
         S_END: begin
            w_wr_data    = END_MARKER;
            w_next_state = S_RUN;
            if (w_full) w_next_state = S_ERR;
            else        w_wr_en      = 1'b1;
         end
         default: ;
      endcase
      if (reload) begin
         w_next_state = S_IDLE;
         w_wr_en      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || reload) begin
         r_state      <= S_IDLE;
         r_cnt        <= 2'd0;
         r_asm        <= 32'd0;
         r_word_count <= '0;
`ifdef LOAD_CHECKSUM_EN
         r_sum        <= 8'd0;
`endif
      end else begin
         r_state <= w_next_state;
         if (w_take) begin
            r_cnt <= r_cnt + 2'd1;
            // Lane 0 restarts the word so a padded partial word has zero upper lanes.
            if (r_cnt == 2'd0) r_asm <= {24'd0, load_byte};
            else               r_asm[{r_cnt, 3'b000} +: 8] <= load_byte;
`ifdef LOAD_CHECKSUM_EN
            r_sum <= r_sum + load_byte;
`endif
         end
         if (w_wr_en) r_word_count <= r_word_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_lo[r_word_count[N-1:0]] <= w_wr_data[15:0];
         r_hi[r_word_count[N-1:0]] <= w_wr_data[31:16];
      end
   end

   assign w_idx      = address[N+1:2];
   assign w_idx_nx   = w_idx + N'(1);
   assign w_in_range = ((address >> (N + 2)) == 32'd0);
   assign w_cur_ok   = ({1'b0, w_idx} < r_word_count);
   assign w_nx_ok    = ({1'b0, w_idx_nx} < r_word_count);

   // A straddling read takes the upper half from the next word, wrapping at the top.
   always_comb begin
      data = 32'd0;
      if ((r_state == S_RUN) && !address[0] && w_in_range) begin
         if (!address[1]) begin
            if (w_cur_ok) data = {r_hi[w_idx], r_lo[w_idx]};
         end else begin
            if (w_cur_ok) data[15:0]  = r_hi[w_idx];
            if (w_nx_ok)  data[31:16] = r_lo[w_idx_nx];
         end
      end
   end

endmodule
